// File: rtl/fsqrt_s_ctrl_pkg.sv
// Shared binary32 constants and rounding-mode encodings for the FPU square-root sequencer.
package fsqrt_s_ctrl_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } rm_e;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF   = 32'h7F80_0000;
  localparam int          EXP_BIAS  = 127;

endpackage

// File: rtl/sqrt_24.sv
// Iterative restoring square-root core: one root bit per cycle, 36-bit root with one integer bit.
module sqrt_24 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_exp_odd,
  input  logic [23:0] significand,
  output logic        done,
  output logic [35:0] sq_root
);

  logic [71:0] rad_q;
  logic [36:0] rem_q;
  logic [5:0]  cnt_q;
  logic        busy_q;
  logic [38:0] rem_shift;
  logic [38:0] trial;
  logic        fits;

  assign rem_shift = {rem_q, rad_q[71:70]};
  assign trial     = {1'b0, sq_root, 2'b01};
  assign fits      = (rem_shift >= trial);

  // Count 0 is a settle cycle, counts 1..36 produce root bits, count 37 signals done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rad_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done    <= 1'b0;
      sq_root <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        // Odd exponents fold one extra factor of two into the radicand.
        rad_q   <= is_exp_odd ? {significand, 48'b0} : {1'b0, significand, 47'b0};
        rem_q   <= '0;
        sq_root <= '0;
        cnt_q   <= '0;
        busy_q  <= 1'b1;
      end else if (busy_q) begin
        cnt_q <= cnt_q + 6'd1;
        if (cnt_q >= 6'd1 && cnt_q <= 6'd36) begin
          rad_q   <= rad_q << 2;
          rem_q   <= fits ? 37'(rem_shift - trial) : rem_shift[36:0];
          sq_root <= {sq_root[34:0], fits};
        end
        if (cnt_q == 6'd37) begin
          done   <= 1'b1;
          busy_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/fsqrt_s_ctrl.sv
// Single-precision square-root sequencer: special-operand bypass, unpack/normalize,
// sqrt_24 control, rounding and packing with NV/NX flags.
module fsqrt_s_ctrl
  import fsqrt_s_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_op,
  input  logic [2:0]  in_rm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_flags
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_ROUND, S_DONE} state_e;

  state_e      state;
  logic [7:0]  exp_q;
  logic [22:0] frac_q;
  logic [2:0]  rm_q;
  logic [4:0]  lz_q;
  logic [35:0] root_q;

  logic        core_start;
  logic        core_done;
  logic [35:0] core_root;

  logic        in_sign;
  logic [7:0]  in_exp;
  logic [22:0] in_frac;
  assign in_sign = in_op[31];
  assign in_exp  = in_op[30:23];
  assign in_frac = in_op[22:0];

  logic        is_special;
  logic [31:0] special_result;
  logic [4:0]  special_flags;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    is_special     = 1'b1;
    special_result = CANON_NAN;
    special_flags  = '0;
    if (in_exp == 8'hFF && in_frac != '0)
      special_flags[FLAG_NV] = ~in_frac[22];
    else if (in_exp == 8'h00 && in_frac == '0)
      special_result = in_op;
    else if (in_sign)
      special_flags[FLAG_NV] = 1'b1;
    else if (in_exp == 8'hFF)
      special_result = POS_INF;
    else
      is_special = 1'b0;
  end

  // Leading zeros of {0,F}; only meaningful for subnormal operands.
  logic [4:0] lz;
  always_comb begin
    lz = 5'd0;
    for (int i = 0; i < 23; i++)
      if (in_frac[i]) lz = 5'(23 - i);
  end

  logic [23:0]       sig_in;
  logic signed [9:0] exp_unb;
  logic              odd;
  logic [7:0]        er;

  always_comb begin
    if (exp_q != 8'h00) begin
      sig_in  = {1'b1, frac_q};
      exp_unb = $signed({2'b00, exp_q}) - 10'sd127;
    end else begin
      sig_in  = {1'b0, frac_q} << lz_q;
      exp_unb = -10'sd126 - $signed({5'b00000, lz_q});
    end
  end

  assign odd = exp_unb[0];
  assign er  = 8'((exp_unb - $signed({9'b0, odd})) >>> 1) + 8'(EXP_BIAS);

  logic        guard;
  logic        sticky;
  logic        inexact;
  logic        inc;
  logic [30:0] mag;
  logic [4:0]  round_flags;
  logic        root_msb_unused;

  assign guard           = root_q[11];
  assign sticky          = |root_q[10:0];
  assign inexact         = guard | sticky;
  assign root_msb_unused = root_q[35];

  always_comb begin
    unique case (rm_e'(rm_q))
      RM_RTZ, RM_RDN: inc = 1'b0;
      RM_RUP:         inc = inexact;
      RM_RMM:         inc = guard;
      default:        inc = guard & (sticky | root_q[12]);
    endcase
  end

  // A fraction carry ripples straight into the exponent field.
  assign mag = {er, root_q[34:12]} + 31'(inc);

  always_comb begin
    round_flags          = '0;
    round_flags[FLAG_NX] = inexact;
  end

  sqrt_24 u_sqrt_24 (
    .clk         (clk),
    .reset       (reset),
    .start       (core_start),
    .is_exp_odd  (odd),
    .significand (sig_in),
    .done        (core_done),
    .sq_root     (core_root)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
      core_start <= 1'b0;
      exp_q      <= '0;
      frac_q     <= '0;
      rm_q       <= '0;
      lz_q       <= '0;
      root_q     <= '0;
    end else begin
      core_start <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            exp_q    <= in_exp;
            frac_q   <= in_frac;
            rm_q     <= in_rm;
            lz_q     <= lz;
            in_ready <= 1'b0;
            if (is_special) begin
              out_result <= special_result;
              out_flags  <= special_flags;
              out_valid  <= 1'b1;
              state      <= S_DONE;
            end else begin
              core_start <= 1'b1;
              state      <= S_START;
            end
          end
        end
        S_START: state <= S_WAIT;
        S_WAIT: begin
          if (core_done) begin
            root_q <= core_root;
            state  <= S_ROUND;
          end
        end
        S_ROUND: begin
          out_result <= {1'b0, mag};
          out_flags  <= round_flags;
          out_valid  <= 1'b1;
          state      <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
